window_integral_40mhz: RTL



---
 rtl/window_integral_40mhz_pkg.sv | 10 +
 rtl/window_integral_40mhz_if.sv | 13 +
 rtl/window_integral_40mhz_delay_ram.sv | 18 +
 rtl/window_integral_40mhz.sv | 90 +++++++++
 4 files changed

// File: rtl/window_integral_40mhz_pkg.sv
// window_integral_40mhz_pkg: shared widths, window defaults and state type for the window integrator
package window_integral_40mhz_pkg;
  localparam int ADC_WIDTH = 12;
  localparam int COMPATIBILITY_INTEGRAL_BITS = 16;
  localparam int ADC_MAX = (1 << ADC_WIDTH) - 1;
  localparam int WINTEG_DEFAULT_LEN = 120;
  localparam int WINTEG_BASE_FRAC = 6;
  localparam int WINTEG_BASE_GATE = 20;
  typedef enum logic [1:0] {INIT, FILL, RUN} win_state_t;
endpackage

// File: rtl/window_integral_40mhz_if.sv
// window_integral_40mhz_if: phase bus, sample input and integral/baseline outputs of one channel
interface window_integral_40mhz_if
  import window_integral_40mhz_pkg::*;
;
  logic [1:0] enable40;
  logic [ADC_WIDTH-1:0] adc;
  logic clear;
  logic [COMPATIBILITY_INTEGRAL_BITS-1:0] integral;
  logic integral_valid;
  logic [ADC_WIDTH-1:0] baseline;
  modport master(output enable40, adc, clear, input integral, integral_valid, baseline);
  modport slave(input enable40, adc, clear, output integral, integral_valid, baseline);
endinterface

// File: rtl/window_integral_40mhz_delay_ram.sv
// integral_delay_ram: single-port RAM with registered read-first output, holds one window of diffs
module integral_delay_ram #(
  parameter int DEPTH = 120,
  parameter int WIDTH = 12,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic we,
  input  logic [AW-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/window_integral_40mhz.sv
// window_integral_40mhz: baseline-subtracted, zero-clipped sliding-window integral of one 40 MHz ADC channel
module window_integral_40mhz
  import window_integral_40mhz_pkg::*;
#(
  parameter int WINDOW_LEN = WINTEG_DEFAULT_LEN,
  parameter int BASE_FRAC = WINTEG_BASE_FRAC,
  parameter int BASE_GATE = WINTEG_BASE_GATE
) (
  input logic clk120,
  input logic reset_n,
  window_integral_40mhz_if.slave bus
);
  localparam int SUM_W = $clog2(WINDOW_LEN * ADC_MAX + 1);
  localparam int PTR_W = $clog2(WINDOW_LEN);
  localparam int CNT_W = $clog2(WINDOW_LEN + 1);
  localparam int ACC_W = ADC_WIDTH + BASE_FRAC;
  localparam int INT_W = COMPATIBILITY_INTEGRAL_BITS;
  localparam int INT_MAX = (1 << INT_W) - 1;
  win_state_t state, state_nx;
  logic armed, step, fill_open, gate_ok;
  logic [ADC_WIDTH-1:0] sample, diff, diff_nx, old, base, wdata;
  logic signed [ADC_WIDTH:0] sdiff;
  logic [PTR_W-1:0] wptr;
  logic [CNT_W-1:0] fill_cnt;
  logic [SUM_W-1:0] sum, sum_nx;
  logic [ACC_W-1:0] base_acc, acc_nx;
  logic [31:0] sum_ext;
  logic [INT_W-1:0] integral;
  assign base = base_acc[ACC_W-1 -: ADC_WIDTH];
  assign sdiff = $signed({1'b0, sample}) - $signed({1'b0, base});
  assign diff_nx = sdiff[ADC_WIDTH] ? '0 : sdiff[ADC_WIDTH-1:0];
  assign gate_ok = (sample > base ? sample - base : base - sample) <= ADC_WIDTH'(BASE_GATE);
  assign acc_nx = !gate_ok ? base_acc :
                  (sample > base && base_acc != '1) ? base_acc + 1'b1 :
                  (sample < base && base_acc != '0) ? base_acc - 1'b1 : base_acc;
  assign step = armed && bus.enable40 == 2'd2 && !bus.clear;
  // the slot written on the FILL->RUN sample already holds a windowed value, so it is subtracted
  assign fill_open = state == FILL && fill_cnt != CNT_W'(WINDOW_LEN);
  assign sum_nx = sum + SUM_W'(diff) - (fill_open ? '0 : SUM_W'(old));
  assign sum_ext = 32'(sum_nx);
  assign wdata = state == INIT ? '0 : diff;
  assign bus.integral = integral;
  assign bus.integral_valid = state == RUN;
  assign bus.baseline = base;
  integral_delay_ram #(.DEPTH(WINDOW_LEN), .WIDTH(ADC_WIDTH)) u_ram (
    .clk(clk120), .we(step), .addr(wptr), .wdata(wdata), .rdata(old)
  );
  always_comb begin
    state_nx = state;
    if (bus.clear) state_nx = FILL;
    else if (step) state_nx = state == INIT ? FILL : (state == FILL && !fill_open) ? RUN : state;
  end
  always_ff @(posedge clk120 or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      armed <= 1'b0;
      sample <= '0;
      diff <= '0;
      wptr <= '0;
      fill_cnt <= '0;
      sum <= '0;
      base_acc <= '0;
      integral <= '0;
    end else begin
      state <= state_nx;
      if (bus.enable40 == 2'd0) begin
        sample <= bus.adc;
        armed <= 1'b1;
      end
      if (armed && bus.enable40 == 2'd1) diff <= diff_nx;
      if (bus.clear) begin
        sum <= '0;
        integral <= '0;
        fill_cnt <= '0;
        wptr <= '0;
      end else if (step) begin
        wptr <= wptr == PTR_W'(WINDOW_LEN - 1) ? '0 : wptr + 1'b1;
        if (state == INIT) begin
          base_acc <= ACC_W'(sample) << BASE_FRAC;
          fill_cnt <= CNT_W'(1);
        end else begin
          base_acc <= acc_nx;
          sum <= sum_nx;
          integral <= sum_ext > 32'(INT_MAX) ? INT_W'(INT_MAX) : INT_W'(sum_ext);
          if (fill_open) fill_cnt <= fill_cnt + 1'b1;
        end
      end
    end
  end
endmodule
